// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RV32I load/store funct3 encodings
//   - default data_memory size in bytes
//   - FSM state encoding
//   - lsu_req_error(): decides whether a request is rejected without
//     touching memory (bad funct3, misaligned, or out of range)
// ----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned LSU_MEM_BYTES = 128;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        DONE
    } lsu_state_e;

    // Range is judged on the whole containing word, because data_memory is
    // only ever accessed a word at a time.
    function automatic logic lsu_req_error(
        input logic        write,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input logic [31:0] mem_bytes
    );
        logic bad_funct3;
        logic misaligned;
        logic out_of_range;
        bad_funct3   = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                       || (write && funct3[2]);
        misaligned   = ((funct3 == F3_H || funct3 == F3_HU) && addr[0])
                       || (funct3 == F3_W && addr[1:0] != 2'b00);
        out_of_range = ({addr[31:2], 2'b00} + 32'd3) >= mem_bytes;
        return bad_funct3 || misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// load_store_unit_if
// Bundles the request/response handshake with the execute stage and the
// word-wide port to data_memory.
//   slave  : the load/store unit side
//   master : the execute stage + data_memory side (the testbench)
// Signals:
//   req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata : request
//   resp_valid/resp_rdata/resp_err                              : response
//   mem_address/mem_write_data/mem_read/mem_write/mem_read_data : memory
// ----------------------------------------------------------------------------
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_address, mem_write_data, mem_read, mem_write
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_address, mem_write_data, mem_read, mem_write
    );

endinterface

// File: rtl/lsu_lane_align.sv
// ----------------------------------------------------------------------------
// lsu_lane_align  (purely combinational)
// Moves bytes/halfwords between their lane in a memory word and the core.
// Ports:
//   funct3_i    in  3   access size / signedness
//   lane_i      in  2   byte offset within the word (addr[1:0])
//   load_word_i in  32  word read from data_memory
//   old_word_i  in  32  word to be partially overwritten by a store
//   wdata_i     in  32  store data (low byte/half used for SB/SH)
//   rdata_o     out 32  extracted and extended load result
//   merged_o    out 32  old_word_i with the store lane(s) replaced
// ----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] load_word_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [31:0] merged_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Select the addressed lane, then sign- or zero-extend it.
    always_comb begin
        ld_byte = 8'(load_word_i >> {lane_i, 3'b000});
        ld_half = lane_i[1] ? load_word_i[31:16] : load_word_i[15:0];
        case (funct3_i)
            F3_B:    rdata_o = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   rdata_o = {24'h0, ld_byte};
            F3_H:    rdata_o = {{16{ld_half[15]}}, ld_half};
            F3_HU:   rdata_o = {16'h0, ld_half};
            F3_W:    rdata_o = load_word_i;
            default: rdata_o = 32'h0;
        endcase
    end

    // Overlay the store data on the old word; bytes outside the lane survive.
    always_comb begin
        merged_o = old_word_i;
        case (funct3_i)
            F3_B: merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            F3_H: begin
                if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
                else           merged_o[15:0]  = wdata_i[15:0];
            end
            F3_W:    merged_o = wdata_i;
            default: merged_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Accepts one load/store at a time from the execute stage, validates it and
// performs word-aligned accesses to data_memory. Sub-word stores are done as
// read-modify-write because data_memory only writes whole words.
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  synchronous active-low reset
//   bus    slave modport of load_store_unit_if (request, response, memory)
// Parameter:
//   MEM_BYTES  data_memory size; any access touching byte >= MEM_BYTES errors
// ----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = LSU_MEM_BYTES
)
(
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);

    lsu_state_e  state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        req_err;
    logic [31:0] load_rdata;
    logic [31:0] merged_word;

    assign req_err = lsu_req_error(bus.req_write, bus.req_funct3,
                                   bus.req_addr, MEM_BYTES);

    lsu_lane_align u_lane_align (
        .funct3_i    (funct3_q),
        .lane_i      (addr_q[1:0]),
        .load_word_i (bus.mem_read_data),
        .old_word_i  (word_q),
        .wdata_i     (wdata_q),
        .rdata_o     (load_rdata),
        .merged_o    (merged_word)
    );

    // State, request latch and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            word_q       <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            word_q       <= word_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Next-state logic. Response registers are loaded on the way into DONE
    // so they hold their value until the next response.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        word_d       = word_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d  = bus.req_write;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    if (req_err) begin
                        resp_rdata_d = 32'h0;
                        resp_err_d   = 1'b1;
                        state_d      = DONE;
                    end else if (!bus.req_write) begin
                        state_d = RD;
                    end else if (bus.req_funct3 == F3_W) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: state_d = RD_WAIT;
            RD_WAIT: begin
                word_d = bus.mem_read_data;
                if (!write_q) begin
                    resp_rdata_d = load_rdata;
                    resp_err_d   = 1'b0;
                    state_d      = DONE;
                end else begin
                    state_d = WR;
                end
            end
            WR: begin
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
                state_d      = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes are gated by rst_n so a reset cycle never touches memory,
    // which is what makes a reset during WR abort the store cleanly.
    assign bus.req_ready      = (state_q == IDLE);
    assign bus.resp_valid     = (state_q == DONE);
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.resp_err       = resp_err_q;
    assign bus.mem_read       = (state_q == RD) && rst_n;
    assign bus.mem_write      = (state_q == WR) && rst_n;
    assign bus.mem_address    = (state_q inside {RD, RD_WAIT, WR})
                                ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus.mem_write_data = (state_q == WR) ? merged_word : 32'h0;

endmodule
